fir_sm_fifo: RTL and testbench
==============================

FIR_SM_FIFO -- requirements
Module: fir_sm_fifo

Interface
REQ-001 Parameter pDATA_WIDTH, default 32: AXI-Stream data width.
REQ-002 Parameter pDEPTH, default 8: FIFO entry count; power of two, 2..64.
REQ-003 Parameter pCNT_WIDTH, default 16: width of the packet counter.
REQ-004 axis_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 axis_rst  in  1  reset; synchronous, active-high.
REQ-006 s_tvalid  in  1  upstream beat valid; driven by the FIR sm_tvalid.
REQ-007 s_tdata  in  pDATA_WIDTH  upstream data; driven by the FIR sm_tdata.
REQ-008 s_tlast  in  1  upstream end-of-stream marker; driven by the FIR sm_tlast.
REQ-009 s_tready  out  1  FIFO can accept a beat; drives the FIR sm_tready.
REQ-010 m_tvalid  out  1  downstream beat valid.
REQ-011 m_tdata  out  pDATA_WIDTH  downstream data.
REQ-012 m_tlast  out  1  downstream end-of-stream marker.
REQ-013 m_tready  in  1  downstream ready.
REQ-014 flush  in  1  synchronous clear of all stored beats.
REQ-015 level  out  log2(pDEPTH)+1  number of stored beats.
REQ-016 pkt_cnt  out  pCNT_WIDTH  count of tlast beats delivered downstream.

Function
REQ-017 Write beat: s_tvalid && s_tready at a clock edge stores {s_tlast, s_tdata} at the write pointer; the write pointer advances modulo pDEPTH.
REQ-018 Read beat: m_tvalid && m_tready at a clock edge retires the head entry; the read pointer advances modulo pDEPTH.
REQ-019 s_tready = !full, where full means level == pDEPTH; it is registered and does not depend combinationally on m_tready (no pass-through when full).
REQ-020 m_tvalid = (level != 0); m_tdata and m_tlast come from the head entry (first-word-fall-through).
REQ-021 Latency: a beat accepted at edge N is visible on m_* after edge N; minimum latency is 1 cycle. There is no combinational s_* to m_* path.
REQ-022 Simultaneous read and write with 0 < level < pDEPTH: both occur and level is unchanged.
REQ-023 Read and write in the same cycle at level == 0 is impossible, because m_tvalid = 0.
REQ-024 At level == pDEPTH with m_tready = 1: the read occurs, no write occurs, and s_tready rises the next cycle.
REQ-025 Once m_tvalid is asserted, m_tdata and m_tlast hold stable until the read beat.
REQ-026 Pointers wrap at pDEPTH-1 -> 0 with no lost or duplicated entries.
REQ-027 level increments by 1 on write-only, decrements by 1 on read-only, and never exceeds pDEPTH or goes below 0.
REQ-028 pkt_cnt increments by 1 on each read beat with m_tlast = 1 and wraps from 2^pCNT_WIDTH-1 to 0.
REQ-029 flush = 1: pointers and level go to 0 at the next edge and any write or read in that cycle is discarded; pkt_cnt is preserved.
REQ-030 Stored data is not modified; beat order is preserved.

Reset
REQ-031 While axis_rst = 1 at an edge: pointers = 0, level = 0, pkt_cnt = 0, s_tready = 0, m_tvalid = 0, m_tdata = 0, m_tlast = 0.
REQ-032 s_tready rises on the first edge after axis_rst deasserts.
REQ-033 Reset asserted mid-stream discards all stored beats with no partial output.
REQ-034 Storage array contents need no reset; outputs are masked while level == 0.

Structure
REQ-035 A shared package holds the default width and depth constants and a log2 helper function, shared with the FIR block.
REQ-036 One sub-module, fir_sm_fifo_mem (pDEPTH x (pDATA_WIDTH+1) register array: one write port, one asynchronous read port), is natural; pointer and level control stay in fir_sm_fifo.

Verification
REQ-037 Reset then 8 writes of 0x1..0x8 with m_tready = 0 -> level = 8, s_tready = 0 from the cycle after the 8th beat; a 9th s_tvalid is not accepted.
REQ-038 Full FIFO, then m_tready = 1 for one cycle -> 0x1 is output, level = 7, s_tready = 1 the next cycle; 0x9 is then accepted.
REQ-039 Continuous stream of 20 beats 0x100..0x113 with s_tvalid = m_tready = 1 -> in-order output at 1 beat/cycle after 1-cycle latency; level stays at 1.
REQ-040 Stream of 600 beats with tlast on beat 600, m_tready randomly toggling, pDEPTH = 8 -> output matches input; pkt_cnt = 1 after the last beat.
REQ-041 Level 5, flush pulsed together with s_tvalid = 1 -> level = 0 and m_tvalid = 0 next cycle; the flushed-cycle write is dropped; pkt_cnt is unchanged.
REQ-042 axis_rst asserted for 1 cycle at level 3 -> all outputs and level = 0; s_tready = 1 one cycle after release.

Source files
------------

// File: rtl/fir_sm_fifo_pkg.sv
// Shared constants and helpers for the FIR output stream path.
// The FIR block and its stream FIFO both import this package.
package fir_sm_fifo_pkg;

  localparam int FIR_DATA_WIDTH = 32;
  localparam int FIR_FIFO_DEPTH = 8;
  localparam int FIR_CNT_WIDTH  = 16;

  // Ceiling log2. This is used at elaboration time to size pointers and the level count.
  function automatic int fir_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sm_fifo_if.sv
// AXI-Stream beat bundle (valid/ready/data/last) between the FIR and the stream FIFO.
interface fir_sm_fifo_if
  import fir_sm_fifo_pkg::*;
#(
  parameter int pDATA_WIDTH = FIR_DATA_WIDTH
);

  logic                   tvalid;
  logic                   tready;
  logic [pDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/fir_sm_fifo_mem.sv
// Storage array for the stream FIFO. It has one synchronous write port and one asynchronous read port.
// The contents are never reset. The parent masks the output while the FIFO is empty.
module fir_sm_fifo_mem
  import fir_sm_fifo_pkg::*;
#(
  parameter int pDEPTH = FIR_FIFO_DEPTH,
  parameter int pWIDTH = FIR_DATA_WIDTH + 1
) (
  input  logic                          axis_clk,
  input  logic                          wr_en,
  input  logic [fir_log2(pDEPTH)-1:0]   wr_addr,
  input  logic [pWIDTH-1:0]             wr_data,
  input  logic [fir_log2(pDEPTH)-1:0]   rd_addr,
  output logic [pWIDTH-1:0]             rd_data
);

  logic [pWIDTH-1:0] mem_q [pDEPTH];

  always_ff @(posedge axis_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_sm_fifo.sv
// First-word-fall-through FIFO on the FIR output stream. It also counts delivered end-of-stream beats.
// s_tready is registered from the next level, so no ready path passes through from m_tready.
module fir_sm_fifo
  import fir_sm_fifo_pkg::*;
#(
  parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
  parameter int pDEPTH      = FIR_FIFO_DEPTH,
  parameter int pCNT_WIDTH  = FIR_CNT_WIDTH
) (
  input  logic                        axis_clk,
  input  logic                        axis_rst,
  fir_sm_fifo_if.slave                s_axis,
  fir_sm_fifo_if.master               m_axis,
  input  logic                        flush,
  output logic [fir_log2(pDEPTH):0]   level,
  output logic [pCNT_WIDTH-1:0]       pkt_cnt
);

  localparam int AW = fir_log2(pDEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(pDEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_nxt;
  logic                 s_ready_q;
  logic                 m_valid;
  logic                 wr_en;
  logic                 rd_en;
  logic [pDATA_WIDTH:0] head;

  assign m_valid = (level_q != '0);
  // A beat offered in the same cycle as a flush or reset is dropped.
  assign wr_en   = s_axis.tvalid && s_ready_q && !flush && !axis_rst;
  assign rd_en   = m_valid && m_axis.tready && !flush;

  always_comb begin
    level_nxt = level_q;
    if (wr_en && !rd_en)      level_nxt = level_q + LW'(1);
    else if (rd_en && !wr_en) level_nxt = level_q - LW'(1);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      pkt_cnt   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (head[pDATA_WIDTH]) pkt_cnt <= pkt_cnt + pCNT_WIDTH'(1);
      end
      level_q   <= level_nxt;
      s_ready_q <= (level_nxt != FULL_LEVEL);
    end
  end

  fir_sm_fifo_mem #(
    .pDEPTH (pDEPTH),
    .pWIDTH (pDATA_WIDTH + 1)
  ) u_mem (
    .axis_clk (axis_clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_ptr),
    .wr_data  ({s_axis.tlast, s_axis.tdata}),
    .rd_addr  (rd_ptr),
    .rd_data  (head)
  );

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_valid ? head[pDATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = m_valid & head[pDATA_WIDTH];
  assign level         = level_q;

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Self-checking bench for fir_sm_fifo. A queue model is checked on every cycle,
// and literal expectations are used in the directed scenarios.
module tb_fir_sm_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic          flush    = 1'b0;
  logic [3:0]    level;
  logic [CW-1:0] pkt_cnt;

  fir_sm_fifo_if #(.pDATA_WIDTH(DW)) s_if ();
  fir_sm_fifo_if #(.pDATA_WIDTH(DW)) m_if ();

  fir_sm_fifo #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH),
    .pCNT_WIDTH  (CW)
  ) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .flush    (flush),
    .level    (level),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered queue of stored beats plus the delivered-tlast count.
  logic [DW:0]   mq[$];
  bit            m_rdy = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            n_out = 0;
  bit            m_acc;
  bit            m_rd;

  initial forever begin
    @(posedge axis_clk);
    if (axis_rst) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = '0;
    end else if (flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      m_acc = s_if.tvalid && m_rdy;
      m_rd  = (mq.size() != 0) && m_if.tready;
      if (m_rd) begin
        if (mq[0][DW]) m_cnt = m_cnt + 1'b1;
        void'(mq.pop_front());
        n_out++;
      end
      if (m_acc) mq.push_back({s_if.tlast, s_if.tdata});
      m_rdy = (mq.size() < DEPTH);
    end
  end

  initial forever begin
    @(negedge axis_clk);
    if (chk_en) begin
      chk("s_tready", s_if.tready, m_rdy);
      chk("m_tvalid", m_if.tvalid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("pkt_cnt", pkt_cnt, m_cnt);
      if (mq.size() != 0) begin
        chk("m_tdata", m_if.tdata, mq[0][DW-1:0]);
        chk("m_tlast", m_if.tlast, mq[0][DW]);
      end else begin
        chk("m_tdata_idle", m_if.tdata, 0);
        chk("m_tlast_idle", m_if.tlast, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
    s_if.tvalid  = v;
    s_if.tdata   = d;
    s_if.tlast   = l;
    m_if.tready  = r;
  endtask

  task automatic tick();
    @(negedge axis_clk);
  endtask

  int idx;
  int cyc;
  int out0;
  bit v;
  bit acc;

  initial begin
    drive(0, 0, 0, 0);
    axis_rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_level", level, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    axis_rst = 1'b0;
    tick();
    chk("tready_after_rst", s_if.tready, 1);

    // Fill to full with the downstream stalled; the 8th beat carries tlast.
    for (int i = 1; i <= 8; i++) begin
      drive(1, DW'(i), i == 8, 0);
      tick();
    end
    chk("full_level", level, 8);
    chk("full_tready", s_if.tready, 0);
    drive(1, 32'h9, 0, 0);
    tick();
    chk("no_9th_level", level, 8);
    chk("head_is_1", m_if.tdata, 1);

    drive(1, 32'h9, 0, 1);
    tick();
    chk("pop_level", level, 7);
    chk("pop_tready", s_if.tready, 1);
    chk("head_is_2", m_if.tdata, 2);
    drive(1, 32'h9, 0, 0);
    tick();
    chk("accept_9_level", level, 8);
    drive(0, 0, 0, 1);
    repeat (9) tick();
    chk("drained_tvalid", m_if.tvalid, 0);
    chk("pkt_after_drain", pkt_cnt, 1);

    // Continuous stream with ready held high.
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h100 + DW'(i), 0, 1);
      tick();
      chk("stream_level", level, 1);
      chk("stream_data", m_if.tdata, 32'h100 + DW'(i));
    end
    drive(0, 0, 0, 1);
    tick();
    chk("stream_empty", level, 0);

    // Flush at level 5 while a write and a read are offered.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h200 + DW'(i), 0, 0);
      tick();
    end
    chk("pre_flush_level", level, 5);
    drive(1, 32'hdead, 1, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    chk("flush_level", level, 0);
    chk("flush_tvalid", m_if.tvalid, 0);
    chk("flush_pkt", pkt_cnt, 1);
    tick();
    chk("flush_write_dropped", level, 0);

    // One-cycle reset at level 3.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + DW'(i), 0, 0);
      tick();
    end
    chk("pre_rst_level", level, 3);
    drive(0, 0, 0, 0);
    axis_rst = 1'b1;
    tick();
    chk("midrst_level", level, 0);
    chk("midrst_tvalid", m_if.tvalid, 0);
    chk("midrst_tdata", m_if.tdata, 0);
    chk("midrst_tready", s_if.tready, 0);
    chk("midrst_pkt", pkt_cnt, 0);
    axis_rst = 1'b0;
    tick();
    chk("midrst_tready_rise", s_if.tready, 1);

    // 600-beat stream with random valid and ready; tlast only on the final beat.
    out0 = n_out;
    idx  = 1;
    cyc  = 0;
    while (idx <= 600 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, 32'h5000 + DW'(idx), idx == 600, 1'($urandom_range(0, 1)));
      acc = v && s_if.tready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    chk("stream600_sent", idx, 601);
    drive(0, 0, 0, 1);
    cyc = 0;
    while (m_if.tvalid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("stream600_drained", m_if.tvalid, 0);
    chk("stream600_count", n_out - out0, 600);
    chk("stream600_pkt", pkt_cnt, 1);

    // Seventeen more tlast beats: 18 packets wrap the 4-bit counter to 2.
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h700 + DW'(i), 1, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    chk("pkt_wrap", pkt_cnt, 2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
